// File: rtl/sync_fifo_wl_if.sv
// Handshake/status bundle for sync_fifo_wl. master = producer/consumer side, slave = the FIFO.
// Accepted write = wr_en & ~full; accepted read = rd_en & ~empty, both sampled on the rising clock edge.
interface sync_fifo_wl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);
  logic                  clr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  full;
  logic                  almost_full;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_en;
  logic                  empty;
  logic                  almost_empty;
  logic                  underflow;
  logic [ADDR_WIDTH:0]   water_level;

  modport master (
    output clr, wr_data, wr_en, rd_en,
    input  full, almost_full, overflow, rd_data, empty, almost_empty, underflow, water_level
  );

  modport slave (
    input  clr, wr_data, wr_en, rd_en,
    output full, almost_full, overflow, rd_data, empty, almost_empty, underflow, water_level
  );
endinterface

// File: rtl/sync_fifo_wl.sv
// Single-clock FIFO with registered water level, almost flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle read latency.
module sync_fifo_wl #(
  parameter int ADDR_WIDTH       = 4,
  parameter int DATA_WIDTH       = 16,
  parameter int ALMOST_FULL_NUM  = 11,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic          clk,
  input  logic          rst,
  sync_fifo_wl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0]         AF_C    = CW'(ALMOST_FULL_NUM);
  localparam logic [CW-1:0]         AE_C    = CW'(ALMOST_EMPTY_NUM);
  localparam logic [CW-1:0]         ONE_C   = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PONE_C  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic full_q, full_d, af_q, af_d, empty_q, empty_d, ae_q, ae_d;
  logic ov_q, ov_d, un_q, un_d;
  logic wr_acc, rd_acc;
`ifdef SYNC_FIFO_FWFT_EN
  logic [CW-1:0] ram_cnt_q, ram_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          load;
`endif

  assign wr_acc = bus.wr_en & ~full_q & ~bus.clr;
  assign rd_acc = bus.rd_en & ~empty_q & ~bus.clr;

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    count_d   = count_q;
    ov_d      = bus.wr_en & full_q & ~bus.clr;
    un_d      = bus.rd_en & empty_q & ~bus.clr;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PONE_C;
    if (wr_acc && !rd_acc)      count_d = count_q + ONE_C;
    else if (!wr_acc && rd_acc) count_d = count_q - ONE_C;
`ifdef SYNC_FIFO_FWFT_EN
    // The output register is part of the storage: refill it whenever it is free or being consumed.
    out_valid_d = out_valid_q;
    ram_cnt_d   = ram_cnt_q;
    load        = (ram_cnt_q != '0) && (!out_valid_q || rd_acc) && !bus.clr;
    if (load) begin
      rd_data_d   = mem_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + PONE_C;
      out_valid_d = 1'b1;
    end else if (rd_acc) begin
      out_valid_d = 1'b0;
    end
    if (wr_acc && !load)      ram_cnt_d = ram_cnt_q + ONE_C;
    else if (!wr_acc && load) ram_cnt_d = ram_cnt_q - ONE_C;
    empty_d = ~out_valid_d;
`else
    if (rd_acc) begin
      rd_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PONE_C;
    end
    empty_d = (count_d == '0);
`endif
    if (bus.clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      rd_data_d = '0;
      count_d   = '0;
      empty_d   = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      out_valid_d = 1'b0;
      ram_cnt_d   = '0;
`endif
    end
    full_d = (count_d == DEPTH_C);
    af_d   = (count_d >= AF_C);
    ae_d   = (count_d <= AE_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      empty_q   <= 1'b1;
      ae_q      <= 1'b1;
      ov_q      <= 1'b0;
      un_q      <= 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
      out_valid_q <= 1'b0;
      ram_cnt_q   <= '0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      count_q   <= count_d;
      full_q    <= full_d;
      af_q      <= af_d;
      empty_q   <= empty_d;
      ae_q      <= ae_d;
      ov_q      <= ov_d;
      un_q      <= un_d;
`ifdef SYNC_FIFO_FWFT_EN
      out_valid_q <= out_valid_d;
      ram_cnt_q   <= ram_cnt_d;
`endif
    end
  end

  assign bus.full         = full_q;
  assign bus.almost_full  = af_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ov_q;
  assign bus.underflow    = un_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.water_level  = count_q;
endmodule

// File: doc/sync_fifo_wl.md
# sync_fifo_wl

Parametrised single-clock FIFO, successor to the fixed 16x16 distributed FIFO used between the conv3x3 line buffers and the MAC array. Adds generic depth/width, a live water-level output, sticky-free overflow/underflow pulses, a synchronous clear for frame restarts, and a compile-time first-word-fall-through (FWFT) read mode. Storage is distributed RAM (registers/LUT RAM); all status outputs are registered.

## Interface
- ADDR_WIDTH, 4, depth DEPTH = 2**ADDR_WIDTH (legal 4..10)
- DATA_WIDTH, 16, word width (legal 1..256)
- ALMOST_FULL_NUM, 11, almost_full threshold (legal 1..DEPTH)
- ALMOST_EMPTY_NUM, 4, almost_empty threshold (legal 0..DEPTH-1)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear, active-high
- wr_data  in  DATA_WIDTH  write data
- wr_en  in  1  write request
- full  out  1  count == DEPTH
- almost_full  out  1  count >= ALMOST_FULL_NUM
- overflow  out  1  one-cycle pulse: write requested while full
- rd_data  out  DATA_WIDTH  read data
- rd_en  in  1  read request (FWFT: acknowledge of presented word)
- empty  out  1  no readable word
- almost_empty  out  1  count <= ALMOST_EMPTY_NUM
- underflow  out  1  one-cycle pulse: read requested while empty
- water_level  out  ADDR_WIDTH+1  current word count, 0..DEPTH

## Operation
- Write accepted = wr_en & ~full; read accepted = rd_en & ~empty. full/empty are the registered values of the current cycle.
- Write pointer, read pointer: ADDR_WIDTH bits, wrap DEPTH-1 -> 0 naturally; count held separately (ADDR_WIDTH+1 bits).
- Both accepted same cycle: pointers advance, count unchanged.
- Full with wr_en & rd_en: read accepted, write rejected, overflow pulses. Empty with both: write accepted, read rejected, underflow pulses.
- full, almost_full, almost_empty, water_level are registered from next-count, so they always agree with each other in the same cycle.
- Rejected write: memory and pointers untouched. Rejected read: rd_data holds.
- clr: priority over wr_en/rd_en in the same cycle; returns pointers, count, flags and rd_data to reset values; memory contents not cleared.
- rst mid-operation: immediate return to reset values; in-flight word lost.
- Reset values: full 0, almost_full 0, overflow 0, rd_data 0, empty 1, almost_empty 1, underflow 0, water_level 0.

## Timing
- Standard mode: write at edge N -> water_level/empty updated after edge N. Read accepted at edge M -> rd_data valid after edge M, held until next accepted read.
- FWFT mode: write into empty FIFO at edge N -> head prefetched into output register at edge N+1; empty falls and rd_data valid after N+1. rd_en in a cycle with empty=0 consumes the word; next word appears after the same edge if available (back-to-back reads at full rate).
- FWFT water_level counts the presented word; capacity stays exactly DEPTH.
- overflow/underflow: asserted the cycle after the offending request, one cycle each request.
- Throughput: one write and one read per cycle sustained.

## Configuration
- Macro SYNC_FIFO_FWFT_EN.
- Defined: FWFT read mode as above; rd_data is the head word whenever empty=0.
- Undefined: standard mode; rd_data updates one edge after an accepted read, 1-cycle read latency.

## Test plan
- Reset then write 0x0001..0x0010 (DEPTH=16) -> full=1 after 16th edge, almost_full=1 after 11th, water_level=16; 17th write -> overflow pulse 1 cycle, memory unchanged.
- Read 16 words from full -> data 0x0001..0x0010 in order, almost_empty=1 at level 4, empty=1 at 0; extra rd_en -> underflow pulse, rd_data holds 0x0010.
- Simultaneous wr_en/rd_en at level 8 for 40 cycles -> water_level stays 8, pointers wrap, data order preserved.
- wr_en & rd_en when full, and when empty -> full: read only (level 15); empty: write only (level 1, underflow=1).
- clr asserted with wr_en=1 at level 9 -> level 0, empty=1, rd_data 0, write dropped; async rst mid-burst -> all outputs at reset values immediately.
- SYNC_FIFO_FWFT_EN: write 0xABCD at edge N -> rd_data=0xABCD, empty=0 after N+1 without rd_en; rd_en -> empty=1 next edge.
